// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl
// Moves one register's contents into another over a shared bus on behalf of
// two requesters. A transfer enables the source register onto the bus (e),
// pulses the destination's level-sensitive set input (s) while the source is
// still driving, keeps the source driving for one more cycle, then
// acknowledges the requester. Arbitration between the two requesters is
// round-robin.
//
// Ports
//   clk                 single clock, rising edge
//   reset_n             asynchronous active-low reset
//   req0_valid          transfer request from requester 0, held until req0_ack
//   req0_src, req0_dst  source/destination register index for requester 0
//   req1_valid          transfer request from requester 1, held until req1_ack
//   req1_src, req1_dst  source/destination register index for requester 1
//   req0_ack, req1_ack  one-cycle completion pulse to the granted requester
//   gpr_e               one-hot bus-enable to registers R0..R3
//   gpr_s               one-hot set to registers R0..R3
//   busy                high whenever a transfer is in progress
//
// Parameter
//   SET_CYCLES          number of cycles gpr_s stays high (1..15)
module reg_xfer_ctrl #(
  parameter int unsigned SET_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_src,
  input  logic [1:0] req0_dst,
  input  logic       req1_valid,
  input  logic [1:0] req1_src,
  input  logic [1:0] req1_dst,
  output logic       req0_ack,
  output logic       req1_ack,
  output logic [3:0] gpr_e,
  output logic [3:0] gpr_s,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ENA,
    SET,
    HOLD,
    ACK
  } state_t;

  // The SET counter loads SET_CYCLES-1 and counts down to zero.
  localparam logic [3:0] SET_LAST = 4'(SET_CYCLES - 1);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;   // 0: requester 0, 1: requester 1
  logic       prio_q, prio_d;     // 0: requester 0 wins a tie, 1: requester 1
  logic [1:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gpr_e_q, gpr_e_d;
  logic [3:0] gpr_s_q, gpr_s_d;
  logic       req0_ack_q, req0_ack_d;
  logic       req1_ack_q, req1_ack_d;
  logic       busy_q, busy_d;
  logic       pick1;

  // Next-state logic. The transfer parameters are captured only in IDLE, so
  // anything the requesters do with src/dst afterwards has no effect until the
  // transfer finishes. Every output is derived from the *next* state and next
  // captured values, so the output flops line up with the state they
  // describe while still having no combinational path from the inputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    pick1   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Requester 1 wins when it is alone, or when both ask and the
          // pointer says it is requester 1's turn.
          pick1   = req1_valid && (!req0_valid || prio_q);
          grant_d = pick1;
          src_d   = pick1 ? req1_src : req0_src;
          dst_d   = pick1 ? req1_dst : req0_dst;
          prio_d  = ~pick1;
          state_d = ENA;
        end
      end
      ENA: begin
        cnt_d   = SET_LAST;
        state_d = SET;
      end
      SET: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gpr_e_d = 4'b0000;
    if (state_d == ENA || state_d == SET || state_d == HOLD) begin
      gpr_e_d = 4'b0001 << src_d;
    end

    // A register copied onto itself is never set; the timing is unchanged.
    gpr_s_d = 4'b0000;
    if (state_d == SET && src_d != dst_d) begin
      gpr_s_d = 4'b0001 << dst_d;
    end

    req0_ack_d = (state_d == ACK) && !grant_d;
    req1_ack_d = (state_d == ACK) && grant_d;
    busy_d     = (state_d != IDLE);
  end

  // Single state register for the controller and its registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      src_q      <= 2'd0;
      dst_q      <= 2'd0;
      cnt_q      <= 4'd0;
      gpr_e_q    <= 4'b0000;
      gpr_s_q    <= 4'b0000;
      req0_ack_q <= 1'b0;
      req1_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      gpr_e_q    <= gpr_e_d;
      gpr_s_q    <= gpr_s_d;
      req0_ack_q <= req0_ack_d;
      req1_ack_q <= req1_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign gpr_e    = gpr_e_q;
  assign gpr_s    = gpr_s_q;
  assign req0_ack = req0_ack_q;
  assign req1_ack = req1_ack_q;
  assign busy     = busy_q;

endmodule
